// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the systolic array job sequencer.
package systolic_ctrl_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned PIPE_LAT = 2 * N - 1;
    localparam int unsigned VEC_W    = 4 * DATA_W;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        LOAD_B,
        LATCH_B,
        A_WR,
        SHIFT,
        CAP,
        OUT,
        DONE
    } state_e;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side streams of the sequencer: weight and A inputs, result output.
interface systolic_seq_ctrl_if #(
    parameter int unsigned DATA_W = systolic_ctrl_pkg::DATA_W,
    parameter int unsigned VEC_W  = systolic_ctrl_pkg::VEC_W
);
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_data;
    logic              res_valid;
    logic              res_ready;
    logic [VEC_W-1:0]  res_data;

    modport master (
        output w_valid, w_data, a_valid, a_data, res_ready,
        input  w_ready, a_ready, res_valid, res_data
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, res_ready,
        output w_ready, a_ready, res_valid, res_data
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 4x4 systolic array wrapper: clear, load weights,
// feed/flush A vectors, shift, and return bottom-row results.
module systolic_seq_ctrl #(
    parameter int unsigned DATA_W   = systolic_ctrl_pkg::DATA_W,
    parameter int unsigned N        = systolic_ctrl_pkg::N,
    parameter int unsigned PIPE_LAT = systolic_ctrl_pkg::PIPE_LAT
) (
    input  logic                       Clock,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 num_steps,
    output logic                       busy,
    output logic                       done,
    systolic_seq_ctrl_if.slave         strm,
    output logic                       ext_we,
    output logic                       ext_sel_a_or_b,
    output logic [$clog2(N*N)-1:0]     ext_b_sel,
    output logic [$clog2(N)-1:0]       ext_a_sel,
    output logic [DATA_W-1:0]          ext_wdata,
    output logic [N*N-1:0]             b_we,
    output logic                       data_clear,
    output logic                       en_shift_right,
    output logic                       en_shift_bottom,
    input  logic [N*DATA_W-1:0]        ps_bottom_out
);
    import systolic_ctrl_pkg::*;

    localparam int unsigned CNT_W  = $clog2(N * N);
    localparam int unsigned ASEL_W = $clog2(N);
    localparam int unsigned STEP_W = 9;
    localparam int unsigned RES_W  = N * DATA_W;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   wcnt_q;
    logic [STEP_W-1:0]  step_q;
    logic [7:0]         nsteps_q;
    logic [RES_W-1:0]   res_q;

    logic feed_c;
    logic last_c;
    logic a_acc_c;

    // Feed while A vectors remain, then flush zeros to drain the array.
    assign feed_c  = (step_q <= STEP_W'(nsteps_q));
    assign last_c  = (step_q == STEP_W'(nsteps_q) + STEP_W'(PIPE_LAT) - STEP_W'(1));
    assign a_acc_c = (state_q == A_WR) && (!feed_c || strm.a_valid);

    always_ff @(posedge Clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_steps == 8'd0) ? DONE : CLEAR;
                end
            end
            CLEAR:   state_d = LOAD_B;
            LOAD_B: begin
                if (strm.w_valid && (wcnt_q == CNT_W'(N * N - 1))) begin
                    state_d = LATCH_B;
                end
            end
            LATCH_B: state_d = A_WR;
            A_WR: begin
                if (a_acc_c && (wcnt_q == CNT_W'(N - 1))) begin
                    state_d = SHIFT;
                end
            end
            SHIFT:   state_d = CAP;
            CAP: begin
                if (step_q >= STEP_W'(PIPE_LAT)) begin
                    state_d = OUT;
                end else if (last_c) begin
                    state_d = DONE;
                end else begin
                    state_d = A_WR;
                end
            end
            OUT: begin
                if (strm.res_ready) begin
                    state_d = last_c ? DONE : A_WR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word/step counters and result capture.
    always_ff @(posedge Clock) begin
        if (rst) begin
            wcnt_q   <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            res_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        nsteps_q <= num_steps;
                        wcnt_q   <= '0;
                        step_q   <= STEP_W'(1);
                    end
                end
                LOAD_B: begin
                    if (strm.w_valid) begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    end
                end
                LATCH_B: begin
                    wcnt_q <= '0;
                    step_q <= STEP_W'(1);
                end
                A_WR: begin
                    if (a_acc_c) begin
                        wcnt_q <= (wcnt_q == CNT_W'(N - 1)) ? '0 : wcnt_q + CNT_W'(1);
                    end
                end
                CAP: begin
                    res_q <= ps_bottom_out;
                end
                default: ;
            endcase
            if (((state_q == CAP) || (state_q == OUT)) && (state_d == A_WR)) begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        strm.w_ready    = 1'b0;
        strm.a_ready    = 1'b0;
        strm.res_valid  = 1'b0;
        strm.res_data   = '0;
        ext_we          = 1'b0;
        ext_sel_a_or_b  = 1'b0;
        ext_b_sel       = '0;
        ext_a_sel       = '0;
        ext_wdata       = '0;
        b_we            = '0;
        data_clear      = 1'b0;
        en_shift_right  = 1'b0;
        en_shift_bottom = 1'b0;

        busy = (state_q != IDLE);
        case (state_q)
            CLEAR: data_clear = 1'b1;
            LOAD_B: begin
                strm.w_ready = 1'b1;
                if (strm.w_valid) begin
                    ext_we    = 1'b1;
                    ext_b_sel = wcnt_q;
                    ext_wdata = strm.w_data;
                end
            end
            LATCH_B: b_we = '1;
            A_WR: begin
                strm.a_ready = feed_c;
                if (a_acc_c) begin
                    ext_we         = 1'b1;
                    ext_sel_a_or_b = 1'b1;
                    ext_a_sel      = ASEL_W'(wcnt_q);
                    ext_wdata      = feed_c ? strm.a_data : '0;
                end
            end
            SHIFT: begin
                en_shift_right  = 1'b1;
                en_shift_bottom = 1'b1;
            end
            OUT: begin
                strm.res_valid = 1'b1;
                strm.res_data  = res_q;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural array/wrapper model
// (7-deep bottom-row delay after each shift).
module tb_systolic_seq_ctrl;
    import systolic_ctrl_pkg::*;

    logic              Clock = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        num_steps;
    logic              busy, done;
    logic              ext_we, ext_sel_a_or_b;
    logic [3:0]        ext_b_sel;
    logic [1:0]        ext_a_sel;
    logic [15:0]       ext_wdata;
    logic [15:0]       b_we;
    logic              data_clear, en_shift_right, en_shift_bottom;
    logic [VEC_W-1:0]  ps_bottom_out;

    systolic_seq_ctrl_if sif ();

    systolic_seq_ctrl dut (
        .Clock           (Clock),
        .rst             (rst),
        .start           (start),
        .num_steps       (num_steps),
        .busy            (busy),
        .done            (done),
        .strm            (sif),
        .ext_we          (ext_we),
        .ext_sel_a_or_b  (ext_sel_a_or_b),
        .ext_b_sel       (ext_b_sel),
        .ext_a_sel       (ext_a_sel),
        .ext_wdata       (ext_wdata),
        .b_we            (b_we),
        .data_clear      (data_clear),
        .en_shift_right  (en_shift_right),
        .en_shift_bottom (en_shift_bottom),
        .ps_bottom_out   (ps_bottom_out)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    int cyc, n_clr, n_we, n_done, done_cyc, n_bwr, b_err, n_awr, a_err, n_ahs;
    int oos, unstable, last_hs_cyc, r_wait, r_stall_n, extra_start;
    int w_stall_idx, w_gap, widx, aidx;
    bit a_toggle, prev_stall, hs_w, hs_a;
    logic [63:0] clr_v, wr_v, sh_v, rv_v, dn_v, by_v, bwe_v;
    logic [VEC_W-1:0] resq[$];
    logic [VEC_W-1:0] last_res;
    logic [15:0] wsrc[16];
    logic [15:0] asrc[$];
    logic [9:0]  s_flags;
    logic [37:0] s_bus;
    logic [63:0] s_res;

    logic [15:0] breg[16];
    logic [15:0] pe_w[16];
    logic [15:0] areg[4];
    logic [63:0] dl[7];
    logic        m_we, m_sel, m_clr, m_sh;
    logic [3:0]  m_bsel;
    logic [1:0]  m_asel;
    logic [15:0] m_wdata, m_bwe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_res(input int i);
        if (i < resq.size()) return resq[i];
        return 'x;
    endfunction

    function automatic logic [63:0] matvec();
        logic [63:0] y;
        logic [15:0] acc;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            acc = '0;
            for (int r = 0; r < 4; r++) acc = 16'(acc + areg[r] * pe_w[r*4+c]);
            y[c*16 +: 16] = acc;
        end
        return y;
    endfunction

    task automatic set_b(input logic [15:0] scale);
        for (int k = 0; k < 16; k++) wsrc[k] = ((k / 4) == (k % 4)) ? scale : 16'h0;
    endtask

    task automatic set_a(input int first, input int nvec);
        asrc.delete();
        for (int i = 0; i < 4 * nvec; i++) asrc.push_back(16'(first + i));
    endtask

    // One clock: sample at negedge, update model and stream drivers after posedge.
    task automatic step();
        @(negedge Clock);
        s_flags = {busy, done, sif.w_ready, sif.a_ready, sif.res_valid, ext_we,
                   ext_sel_a_or_b, data_clear, en_shift_right, en_shift_bottom};
        s_bus   = {ext_b_sel, ext_a_sel, ext_wdata, b_we};
        s_res   = sif.res_data;
        if (cyc < 64) begin
            clr_v[cyc] = data_clear;
            wr_v[cyc]  = sif.w_ready;
            sh_v[cyc]  = en_shift_right;
            rv_v[cyc]  = sif.res_valid;
            dn_v[cyc]  = done;
            by_v[cyc]  = busy;
            bwe_v[cyc] = (b_we == 16'hFFFF);
        end
        if (data_clear) n_clr++;
        if (ext_we) n_we++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (ext_we && !ext_sel_a_or_b) begin
            if (ext_b_sel !== 4'(n_bwr)) b_err++;
            n_bwr++;
        end
        if (ext_we && ext_sel_a_or_b) begin
            if (ext_a_sel !== 2'(n_awr)) a_err++;
            if (sif.a_ready && !sif.a_valid) a_err++;
            if (!sif.a_ready && ext_wdata !== 16'h0) a_err++;
            n_awr++;
        end
        if (sif.a_valid && sif.a_ready) begin
            n_ahs++;
            if (!ext_we) a_err++;
        end
        if (sif.res_valid && en_shift_right) oos++;
        if (sif.res_valid && prev_stall && sif.res_data !== last_res) unstable++;
        prev_stall = sif.res_valid && !sif.res_ready;
        last_res   = sif.res_data;
        hs_w = sif.w_valid && sif.w_ready;
        hs_a = sif.a_valid && sif.a_ready;
        if (sif.res_valid && sif.res_ready) begin
            resq.push_back(sif.res_data);
            last_hs_cyc = cyc;
            r_wait = 0;
        end else if (sif.res_valid) begin
            r_wait++;
        end
        m_we = ext_we; m_sel = ext_sel_a_or_b; m_bsel = ext_b_sel; m_asel = ext_a_sel;
        m_wdata = ext_wdata; m_bwe = b_we; m_clr = data_clear; m_sh = en_shift_right;

        @(posedge Clock);
        #1;
        cyc++;
        for (int k = 0; k < 16; k++) if (m_bwe[k]) pe_w[k] = breg[k];
        if (m_we) begin
            if (m_sel) areg[m_asel] = m_wdata;
            else       breg[m_bsel] = m_wdata;
        end
        if (m_clr) for (int i = 0; i < 7; i++) dl[i] = '0;
        if (m_sh) begin
            for (int i = 6; i > 0; i--) dl[i] = dl[i-1];
            dl[0] = matvec();
        end
        ps_bottom_out = dl[6];

        start = (cyc == extra_start);
        if (hs_w) widx++;
        if (hs_a) aidx++;
        if (widx == w_stall_idx && w_gap > 0) begin
            sif.w_valid = 1'b0;
            w_gap--;
        end else begin
            sif.w_valid = 1'b1;
        end
        sif.w_data    = (widx < 16) ? wsrc[widx] : 16'h0;
        sif.a_valid   = a_toggle ? !sif.a_valid : 1'b1;
        sif.a_data    = (aidx < asrc.size()) ? asrc[aidx] : 16'h0;
        sif.res_ready = (r_wait >= r_stall_n);
    endtask

    task automatic job_begin(input logic [7:0] ns);
        cyc = 0; n_clr = 0; n_we = 0; n_done = 0; done_cyc = -1; n_bwr = 0; b_err = 0;
        n_awr = 0; a_err = 0; n_ahs = 0; oos = 0; unstable = 0; last_hs_cyc = -1;
        r_wait = 0; widx = 0; aidx = 0; prev_stall = 0;
        clr_v = '0; wr_v = '0; sh_v = '0; rv_v = '0; dn_v = '0; by_v = '0; bwe_v = '0;
        resq.delete();
        sif.w_valid   = 1'b1;
        sif.w_data    = wsrc[0];
        sif.a_valid   = 1'b1;
        sif.a_data    = (asrc.size() > 0) ? asrc[0] : 16'h0;
        sif.res_ready = (r_stall_n == 0);
        num_steps     = ns;
        start         = 1'b1;
    endtask

    task automatic run_job(input logic [7:0] ns, input int bound);
        job_begin(ns);
        step();
        while (n_done == 0 && cyc < bound) step();
        chk("job_done_seen", 64'(n_done), 64'd1);
        step();
    endtask

    logic [63:0] exp_sh;

    initial begin
        rst = 1'b1; start = 1'b0; num_steps = '0; ps_bottom_out = '0;
        sif.w_valid = 1'b0; sif.w_data = '0; sif.a_valid = 1'b0; sif.a_data = '0;
        sif.res_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin breg[k] = '0; pe_w[k] = '0; wsrc[k] = '0; end
        for (int i = 0; i < 4; i++) areg[i] = '0;
        for (int i = 0; i < 7; i++) dl[i] = '0;
        extra_start = -1; w_stall_idx = -1; w_gap = 0; a_toggle = 0; r_stall_n = 0; cyc = 0;

        // Reset state
        step();
        step();
        chk("rst_flags", 64'(s_flags), 64'd0);
        chk("rst_bus", 64'(s_bus), 64'd0);
        chk("rst_res", s_res, 64'd0);
        rst = 1'b0;
        step();

        // Basic job timing, identity weights, A = {1,2,3,4}
        set_b(16'd1);
        set_a(1, 1);
        run_job(8'd1, 200);
        exp_sh = '0;
        for (int i = 0; i < 7; i++) exp_sh[23 + 6*i] = 1'b1;
        chk("t1_clear", clr_v, 64'h2);
        chk("t1_w_ready", wr_v, 64'h3_FFFC);
        chk("t1_b_we", bwe_v, 64'h4_0000);
        chk("t1_shift", sh_v, exp_sh);
        chk("t1_res_valid", rv_v, 64'h2000_0000_0000_0000);
        chk("t1_done", dn_v, 64'h4000_0000_0000_0000);
        chk("t1_busy", by_v, 64'h7FFF_FFFF_FFFF_FFFE);
        chk("t1_nres", 64'(resq.size()), 64'd1);
        chk("t1_res0", get_res(0), 64'h0004_0003_0002_0001);
        chk("t1_bwr", 64'(n_bwr), 64'd16);

        // Stream stalls: w_valid low 3 cycles at word 7, a_valid toggling
        set_a(5, 2);
        w_stall_idx = 7; w_gap = 3; a_toggle = 1;
        run_job(8'd2, 400);
        w_stall_idx = -1; a_toggle = 0;
        chk("t2_bwr", 64'(n_bwr), 64'd16);
        chk("t2_b_order", 64'(b_err), 64'd0);
        chk("t2_a_order", 64'(a_err), 64'd0);
        chk("t2_a_hs", 64'(n_ahs), 64'd8);
        chk("t2_a_wr", 64'(n_awr), 64'd32);
        chk("t2_res0", get_res(0), 64'h0008_0007_0006_0005);
        chk("t2_res1", get_res(1), 64'h000C_000B_000A_0009);

        // Result backpressure with weights = 2*I
        set_b(16'd2);
        set_a(1, 3);
        r_stall_n = 5;
        run_job(8'd3, 600);
        r_stall_n = 0;
        chk("t3_nres", 64'(resq.size()), 64'd3);
        chk("t3_res0", get_res(0), 64'h0008_0006_0004_0002);
        chk("t3_res1", get_res(1), 64'h0010_000E_000C_000A);
        chk("t3_res2", get_res(2), 64'h0018_0016_0014_0012);
        chk("t3_stable", 64'(unstable), 64'd0);
        chk("t3_no_shift_out", 64'(oos), 64'd0);
        chk("t3_done_after_hs", 64'(done_cyc), 64'(last_hs_cyc + 1));
        chk("t3_a_hs", 64'(n_ahs), 64'd12);

        // Empty job
        set_b(16'd1);
        run_job(8'd0, 20);
        chk("t4_done_cyc", 64'(done_cyc), 64'd1);
        chk("t4_no_clear", 64'(n_clr), 64'd0);
        chk("t4_no_we", 64'(n_we), 64'd0);
        chk("t4_busy", by_v & 64'h7, 64'h2);

        // Start pulsed during LOAD_B is ignored
        set_a(1, 1);
        extra_start = 5;
        run_job(8'd1, 200);
        extra_start = -1;
        chk("t4b_done_cnt", 64'(n_done), 64'd1);
        chk("t4b_done_cyc", 64'(done_cyc), 64'd62);
        chk("t4b_nres", 64'(resq.size()), 64'd1);

        // Reset mid-job during A_WR, then a fresh job
        set_a(100, 2);
        job_begin(8'd2);
        step();
        while (n_awr < 2 && cyc < 200) step();
        chk("t5_reached_a_wr", 64'(n_awr >= 2), 64'd1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("t5_rst_flags", 64'(s_flags), 64'd0);
        chk("t5_rst_bus", 64'(s_bus), 64'd0);
        chk("t5_rst_res", s_res, 64'd0);
        step();
        set_a(5, 2);
        run_job(8'd2, 400);
        chk("t5_nres", 64'(resq.size()), 64'd2);
        chk("t5_res0", get_res(0), 64'h0008_0007_0006_0005);
        chk("t5_res1", get_res(1), 64'h000C_000B_000A_0009);
        chk("t5_bwr", 64'(n_bwr), 64'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
